// File: rtl/riscv_pkg.sv
// -----------------------------------------------------------------------------
// riscv_pkg
//   Shared types and constants for the EX-stage forwarding / hazard logic.
//   - REG_ADDR_W / SEL_W : register-address and forwarding-select widths
//   - FWD_*              : operand-mux select codes (3 is never used)
//   - stage_entry_t      : destination info kept for the MEM and WB stages
//   - ex_entry_t         : full decode info kept for the EX stage
//   - fwd_match()        : "this stage entry supplies register src"
// -----------------------------------------------------------------------------
package riscv_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int SEL_W      = 2;

    typedef logic [REG_ADDR_W-1:0] reg_addr_t;
    typedef logic [SEL_W-1:0]      fwd_sel_t;

    localparam fwd_sel_t FWD_REGFILE = 2'd0;
    localparam fwd_sel_t FWD_EXMEM   = 2'd1;
    localparam fwd_sel_t FWD_MEMWB   = 2'd2;

    typedef struct packed {
        logic      valid;
        reg_addr_t rd;
        logic      reg_write;
    } stage_entry_t;

    typedef struct packed {
        logic      valid;
        reg_addr_t rs1;
        reg_addr_t rs2;
        reg_addr_t rd;
        logic      reg_write;
        logic      mem_read;
    } ex_entry_t;

    // x0 is hard-wired to zero, so a write to it is never a forwarding source.
    function automatic logic fwd_match(input stage_entry_t e, input reg_addr_t src);
        return e.valid && e.reg_write && (e.rd != '0) && (e.rd == src);
    endfunction

endpackage

// File: rtl/fwd_hazard_ctrl_if.sv
// -----------------------------------------------------------------------------
// fwd_hazard_ctrl_if
//   Bundle between the ID/EX pipeline control and the forwarding controller.
//   master (the controller): takes the ID-stage instruction info plus the
//     flush/freeze controls, drives the two operand selects and the stall.
//   slave (the pipeline): the opposite directions.
// -----------------------------------------------------------------------------
interface fwd_hazard_ctrl_if;
    import riscv_pkg::*;

    logic      id_valid;
    reg_addr_t id_rs1;
    reg_addr_t id_rs2;
    reg_addr_t id_rd;
    logic      id_reg_write;
    logic      id_mem_read;
    logic      flush;
    logic      freeze;
    fwd_sel_t  fwd_sel_a;
    fwd_sel_t  fwd_sel_b;
    logic      load_use_stall;

    modport master (
        input  id_valid, id_rs1, id_rs2, id_rd, id_reg_write, id_mem_read,
        input  flush, freeze,
        output fwd_sel_a, fwd_sel_b, load_use_stall
    );

    modport slave (
        output id_valid, id_rs1, id_rs2, id_rd, id_reg_write, id_mem_read,
        output flush, freeze,
        input  fwd_sel_a, fwd_sel_b, load_use_stall
    );

endinterface

// File: rtl/fwd_sel_cmp.sv
// -----------------------------------------------------------------------------
// fwd_sel_cmp
//   Combinational select for one EX operand mux.
//   src_valid : the EX stage holds a real instruction
//   src       : source register read by that operand
//   mem, wb   : destination info of the MEM and WB stages
//   sel       : FWD_EXMEM if MEM supplies src, else FWD_MEMWB if WB does,
//               else FWD_REGFILE. MEM wins because it holds the younger write.
// -----------------------------------------------------------------------------
module fwd_sel_cmp
    import riscv_pkg::*;
(
    input  logic         src_valid,
    input  reg_addr_t    src,
    input  stage_entry_t mem,
    input  stage_entry_t wb,
    output fwd_sel_t     sel
);

    always_comb begin
        // NOTE: default first so every path assigns sel and no latch is inferred.
        sel = FWD_REGFILE;
        if (src_valid) begin
            if (fwd_match(mem, src)) begin
                sel = FWD_EXMEM;
            end else if (fwd_match(wb, src)) begin
                sel = FWD_MEMWB;
            end
        end
    end

endmodule

// File: rtl/fwd_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// fwd_hazard_ctrl
//   Forwarding-select and load-use hazard controller for the EX stage.
//   Keeps a shadow of the EX/MEM/WB destination info and compares it against
//   the EX sources (operand selects) and the ID sources (load-use stall).
//   clk   : rising-edge clock
//   rst_n : synchronous active-low reset, clears all stages
//   bus   : master side of fwd_hazard_ctrl_if (ID info, flush, freeze in;
//           fwd_sel_a, fwd_sel_b, load_use_stall out)
// -----------------------------------------------------------------------------
module fwd_hazard_ctrl
    import riscv_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    fwd_hazard_ctrl_if.master   bus
);

    ex_entry_t    ex;
    stage_entry_t mem;
    stage_entry_t wb;
    logic         stall;

    // A load in EX cannot forward its data to the instruction right behind it;
    // that instruction must wait one cycle until the load reaches MEM/WB.
    always_comb begin
        stall = ex.valid && ex.mem_read && ex.reg_write && (ex.rd != '0) &&
                bus.id_valid &&
                ((bus.id_rs1 == ex.rd) || (bus.id_rs2 == ex.rd));
    end

    assign bus.load_use_stall = stall;

    always_ff @(posedge clk) begin
        // NOTE: reset is sampled on the clock edge here, and all state uses <=
        // so every stage moves from the pre-edge value of the stage before it.
        if (!rst_n) begin
            ex  <= '0;
            mem <= '0;
            wb  <= '0;
        end else if (!bus.freeze) begin
            wb  <= mem;
            mem <= '{valid: ex.valid, rd: ex.rd, reg_write: ex.reg_write};
            // flush and stall together still yield just this one bubble.
            if (bus.flush || stall || !bus.id_valid) begin
                ex <= '0;
            end else begin
                ex <= '{valid:     1'b1,
                        rs1:       bus.id_rs1,
                        rs2:       bus.id_rs2,
                        rd:        bus.id_rd,
                        reg_write: bus.id_reg_write,
                        mem_read:  bus.id_mem_read};
            end
        end
    end

    fwd_sel_cmp u_sel_a (
        .src_valid (ex.valid),
        .src       (ex.rs1),
        .mem       (mem),
        .wb        (wb),
        .sel       (bus.fwd_sel_a)
    );

    fwd_sel_cmp u_sel_b (
        .src_valid (ex.valid),
        .src       (ex.rs2),
        .mem       (mem),
        .wb        (wb),
        .sel       (bus.fwd_sel_b)
    );

endmodule

// File: tb/tb_fwd_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// tb_fwd_hazard_ctrl
//   Directed, table-driven bench for fwd_hazard_ctrl. Each record gives the
//   inputs for one clock cycle and the outputs expected during that cycle
//   (before the next rising edge).
// -----------------------------------------------------------------------------
module tb_fwd_hazard_ctrl;

    typedef struct {
        logic       rst_n;
        logic       id_valid;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic [4:0] rd;
        logic       reg_write;
        logic       mem_read;
        logic       flush;
        logic       freeze;
        logic [1:0] exp_a;
        logic [1:0] exp_b;
        logic       exp_stall;
    } vec_t;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_errors;

    fwd_hazard_ctrl_if bus ();

    fwd_hazard_ctrl dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk(input int rst, input int v, input int rs1, input int rs2,
                                input int rd, input int rw, input int mr, input int fl,
                                input int fz, input int ea, input int eb, input int es);
        vec_t t;
        t.rst_n     = 1'(rst);
        t.id_valid  = 1'(v);
        t.rs1       = 5'(rs1);
        t.rs2       = 5'(rs2);
        t.rd        = 5'(rd);
        t.reg_write = 1'(rw);
        t.mem_read  = 1'(mr);
        t.flush     = 1'(fl);
        t.freeze    = 1'(fz);
        t.exp_a     = 2'(ea);
        t.exp_b     = 2'(eb);
        t.exp_stall = 1'(es);
        return t;
    endfunction

    task automatic check(input string name, input logic [4:0] act, input logic [4:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got sel_a=%0d sel_b=%0d stall=%0b, expected sel_a=%0d sel_b=%0d stall=%0b",
                     name, act[4:3], act[2:1], act[0], exp[4:3], exp[2:1], exp[0]);
        end
    endtask

    // Drive one cycle's inputs after the falling edge, sample mid-cycle.
    task automatic cyc(input vec_t t, input string name);
        @(negedge clk);
        rst_n            = t.rst_n;
        bus.id_valid     = t.id_valid;
        bus.id_rs1       = t.rs1;
        bus.id_rs2       = t.rs2;
        bus.id_rd        = t.rd;
        bus.id_reg_write = t.reg_write;
        bus.id_mem_read  = t.mem_read;
        bus.flush        = t.flush;
        bus.freeze       = t.freeze;
        #1;
        check(name, {bus.fwd_sel_a, bus.fwd_sel_b, bus.load_use_stall},
                    {t.exp_a, t.exp_b, t.exp_stall});
    endtask

    vec_t tbl [32];

    initial begin
        n_checks = 0;
        n_errors = 0;

        //            rst v rs1 rs2 rd rw mr fl fz  a  b  s
        // second reset cycle, then release
        tbl[0]  = mk(0, 1,  9,  9, 9, 1, 1, 0, 0, 0, 0, 0);
        tbl[1]  = mk(1, 0,  0,  0, 0, 0, 0, 0, 0, 0, 0, 0);
        // EX/MEM forwarding on A only
        tbl[2]  = mk(1, 1,  1,  2, 5, 1, 0, 0, 0, 0, 0, 0);
        tbl[3]  = mk(1, 1,  5,  3, 6, 1, 0, 0, 0, 0, 0, 0);
        tbl[4]  = mk(1, 0,  0,  0, 0, 0, 0, 0, 0, 1, 0, 0);
        tbl[5]  = mk(1, 0,  0,  0, 0, 0, 0, 0, 0, 0, 0, 0);
        tbl[6]  = mk(1, 0,  0,  0, 0, 0, 0, 0, 0, 0, 0, 0);
        // two writers to x7: MEM beats WB
        tbl[7]  = mk(1, 1,  1,  2, 7, 1, 0, 0, 0, 0, 0, 0);
        tbl[8]  = mk(1, 1,  1,  2, 7, 1, 0, 0, 0, 0, 0, 0);
        tbl[9]  = mk(1, 1,  7,  7, 8, 1, 0, 0, 0, 0, 0, 0);
        tbl[10] = mk(1, 0,  0,  0, 0, 0, 0, 0, 0, 1, 1, 0);
        tbl[11] = mk(1, 0,  0,  0, 0, 0, 0, 0, 0, 0, 0, 0);
        // two writers to x0: never forwarded
        tbl[12] = mk(1, 1,  1,  2, 0, 1, 0, 0, 0, 0, 0, 0);
        tbl[13] = mk(1, 1,  1,  2, 0, 1, 0, 0, 0, 0, 0, 0);
        tbl[14] = mk(1, 1,  0,  0, 8, 1, 0, 0, 0, 0, 0, 0);
        tbl[15] = mk(1, 0,  0,  0, 0, 0, 0, 0, 0, 0, 0, 0);
        tbl[16] = mk(1, 0,  0,  0, 0, 0, 0, 0, 0, 0, 0, 0);
        // MEM/WB forwarding on A (one gap between writer and reader)
        tbl[17] = mk(1, 1,  1,  2,10, 1, 0, 0, 0, 0, 0, 0);
        tbl[18] = mk(1, 0,  0,  0, 0, 0, 0, 0, 0, 0, 0, 0);
        tbl[19] = mk(1, 1, 10, 11,12, 1, 0, 0, 0, 0, 0, 0);
        tbl[20] = mk(1, 0,  0,  0, 0, 0, 0, 0, 0, 2, 0, 0);
        tbl[21] = mk(1, 0,  0,  0, 0, 0, 0, 0, 0, 0, 0, 0);
        // producer without reg_write: no forwarding
        tbl[22] = mk(1, 1,  1,  2,13, 0, 0, 0, 0, 0, 0, 0);
        tbl[23] = mk(1, 1, 13, 13,14, 0, 0, 0, 0, 0, 0, 0);
        tbl[24] = mk(1, 0,  0,  0, 0, 0, 0, 0, 0, 0, 0, 0);
        tbl[25] = mk(1, 0,  0,  0, 0, 0, 0, 0, 0, 0, 0, 0);
        // load x9 then reader on rs2: one stall, then forward from WB
        tbl[26] = mk(1, 1,  1,  2, 9, 1, 1, 0, 0, 0, 0, 0);
        tbl[27] = mk(1, 1,  3,  9,15, 1, 0, 0, 0, 0, 0, 1);
        tbl[28] = mk(1, 1,  3,  9,15, 1, 0, 0, 0, 0, 0, 0);
        tbl[29] = mk(1, 0,  0,  0, 0, 0, 0, 0, 0, 0, 2, 0);
        tbl[30] = mk(1, 0,  0,  0, 0, 0, 0, 0, 0, 0, 0, 0);
        tbl[31] = mk(1, 0,  0,  0, 0, 0, 0, 0, 0, 0, 0, 0);

        // First reset cycle: state is unknown until this edge, so no check.
        rst_n            = 1'b0;
        bus.id_valid     = 1'($urandom);
        bus.id_rs1       = 5'($urandom);
        bus.id_rs2       = 5'($urandom);
        bus.id_rd        = 5'($urandom);
        bus.id_reg_write = 1'($urandom);
        bus.id_mem_read  = 1'($urandom);
        bus.flush        = 1'b0;
        bus.freeze       = 1'b0;
        @(posedge clk);

        foreach (tbl[i]) cyc(tbl[i], $sformatf("vec%0d", i));

        // Flushed writer to x4 must not forward to the following reader.
        cyc(mk(1, 1, 1, 2, 4, 1, 0, 1, 0, 0, 0, 0), "flush_issue");
        cyc(mk(1, 1, 4, 5, 6, 1, 0, 0, 0, 0, 0, 0), "flush_reader");
        cyc(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), "flush_no_fwd");
        cyc(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), "flush_drain1");
        cyc(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), "flush_drain2");

        // Flush and load-use together: exactly one bubble.
        cyc(mk(1, 1, 1, 2, 9, 1, 1, 0, 0, 0, 0, 0), "fs_load");
        cyc(mk(1, 1, 9, 3,15, 1, 0, 1, 0, 0, 0, 1), "fs_flush_stall");
        cyc(mk(1, 1, 9, 3,15, 1, 0, 0, 0, 0, 0, 0), "fs_reissue");
        cyc(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 2, 0, 0), "fs_fwd_wb");
        cyc(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), "fs_drain1");
        cyc(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), "fs_drain2");

        // Freeze for 3 cycles with a load-use hazard pending and A forwarding.
        cyc(mk(1, 1, 1, 2, 5, 1, 0, 0, 0, 0, 0, 0), "fz_w5");
        cyc(mk(1, 1, 5, 2, 9, 1, 1, 0, 0, 0, 0, 0), "fz_ld9");
        for (int k = 0; k < 3; k++)
            cyc(mk(1, 1, 3, 9,15, 1, 0, 0, 1, 1, 0, 1), $sformatf("fz_hold%0d", k));
        cyc(mk(1, 1, 3, 9,15, 1, 0, 0, 0, 1, 0, 1), "fz_release");
        cyc(mk(1, 1, 3, 9,15, 1, 0, 0, 0, 0, 0, 0), "fz_bubble");
        cyc(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2, 0), "fz_fwd_wb");
        cyc(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), "fz_drain");

        // Reset in the middle of traffic discards everything in flight.
        cyc(mk(1, 1, 1, 2, 7, 1, 0, 0, 0, 0, 0, 0), "rst_w7");
        cyc(mk(1, 1, 7, 7, 8, 1, 0, 0, 0, 0, 0, 0), "rst_reader");
        cyc(mk(0, 1, 8, 7, 9, 1, 0, 0, 0, 1, 1, 0), "rst_assert");
        cyc(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), "rst_cleared");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
